// File: rtl/fsm_tx_uart_pkg.sv
// fsm_tx_uart_pkg: shared state encoding, control-register bit positions and timeout default.
package fsm_tx_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, CLEAR} state_t;
  localparam int CTRL_SEND_BIT = 0;
  localparam int CTRL_ERR_BIT = 1;
  localparam int TIMEOUT_CYCLES_DEF = 1024;
endpackage

// File: rtl/fsm_tx_uart_if.sv
// fsm_tx_uart_if: control-register and UART transmitter handshake bundle.
interface fsm_tx_uart_if;
  logic [31:0] control_i;
  logic tx_done_i;
  logic tx_start_o;
  logic we_reg_control;
  logic [31:0] control_o;
  modport master (output control_i, output tx_done_i, input tx_start_o, input we_reg_control, input control_o);
  modport slave (input control_i, input tx_done_i, output tx_start_o, output we_reg_control, output control_o);
endinterface

// File: rtl/fsm_tx_uart_timer.sv
// fsm_tx_uart_timer: WAIT_DONE watchdog, compiled only with FSM_TX_UART_TIMEOUT_EN.
`ifdef FSM_TX_UART_TIMEOUT_EN
module fsm_tx_uart_timer
  import fsm_tx_uart_pkg::*;
#(parameter int CYCLES = TIMEOUT_CYCLES_DEF)
(
  input logic clk,
  input logic rst,
  input logic enable,
  output logic expired
);
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
  logic [W-1:0] count;
  always_ff @(posedge clk) count <= (rst || !enable) ? '0 : count + 1'b1;
  assign expired = enable && (count == W'(CYCLES - 1));
endmodule
`endif

// File: rtl/fsm_tx_uart.sv
// fsm_tx_uart: Moore sequencer issuing a UART start pulse then a control-register clear.
// Optional WAIT_DONE abort with error flag under FSM_TX_UART_TIMEOUT_EN.
module fsm_tx_uart
  import fsm_tx_uart_pkg::*;
#(parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF)
(
  input logic clk_i,
  input logic rst_i,
  fsm_tx_uart_if.slave bus
);
  state_t state;
  logic expired, err;
`ifdef FSM_TX_UART_TIMEOUT_EN
  fsm_tx_uart_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk_i),
    .rst(rst_i),
    .enable(state == WAIT_DONE),
    .expired(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif
  always_comb begin
    bus.control_o = bus.control_i;
    bus.control_o[CTRL_SEND_BIT] = 1'b0;
    bus.control_o[CTRL_ERR_BIT] = bus.control_i[CTRL_ERR_BIT] | err;
  end
  // Outputs are registered alongside the state so they track it exactly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      bus.tx_start_o <= 1'b0;
      bus.we_reg_control <= 1'b0;
      err <= 1'b0;
    end else begin
      bus.tx_start_o <= 1'b0;
      bus.we_reg_control <= 1'b0;
      case (state)
        IDLE: if (bus.control_i[CTRL_SEND_BIT]) begin
          state <= START;
          bus.tx_start_o <= 1'b1;
        end
        START: state <= WAIT_DONE;
        WAIT_DONE: if (bus.tx_done_i || expired) begin
          state <= CLEAR;
          bus.we_reg_control <= 1'b1;
          err <= expired && !bus.tx_done_i;
        end
        default: begin
          state <= IDLE;
          err <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fsm_tx_uart.sv
// tb_fsm_tx_uart: directed vector table plus multi-cycle sequences for fsm_tx_uart.
module tb_fsm_tx_uart;
  import fsm_tx_uart_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  fsm_tx_uart_if bus();
  fsm_tx_uart #(.TIMEOUT_CYCLES(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic rst;
    logic [31:0] ctrl;
    logic done;
    logic start;
    logic we;
    logic [31:0] ctrl_o;
    state_t st;
  } vec_t;
  vec_t vt[25];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int starts, wes, both, waits;
    bus.control_i = 32'h1;
    bus.tx_done_i = 1'b0;
    vt[0]  = '{1, 32'h1, 0, 0, 0, 32'h0, IDLE};
    vt[1]  = '{1, 32'h1, 0, 0, 0, 32'h0, IDLE};
    vt[2]  = '{0, 32'h1, 0, 1, 0, 32'h0, START};
    vt[3]  = '{0, 32'h1, 0, 0, 0, 32'h0, WAIT_DONE};
    vt[4]  = '{0, 32'h1, 0, 0, 0, 32'h0, WAIT_DONE};
    vt[5]  = '{0, 32'h1, 0, 0, 0, 32'h0, WAIT_DONE};
    vt[6]  = '{0, 32'h1, 0, 0, 0, 32'h0, WAIT_DONE};
    vt[7]  = '{0, 32'h1, 0, 0, 0, 32'h0, WAIT_DONE};
    vt[8]  = '{0, 32'h1, 1, 0, 1, 32'h0, CLEAR};
    vt[9]  = '{0, 32'h0, 1, 0, 0, 32'h0, IDLE};
    vt[10] = '{0, 32'h0, 1, 0, 0, 32'h0, IDLE};
    vt[11] = '{0, 32'hA5A5_0005, 0, 1, 0, 32'hA5A5_0004, START};
    vt[12] = '{0, 32'hA5A5_0005, 0, 0, 0, 32'hA5A5_0004, WAIT_DONE};
    vt[13] = '{0, 32'hA5A5_0005, 1, 0, 1, 32'hA5A5_0004, CLEAR};
    vt[14] = '{0, 32'hA5A5_0004, 0, 0, 0, 32'hA5A5_0004, IDLE};
    vt[15] = '{0, 32'h0, 1, 0, 0, 32'h0, IDLE};
    vt[16] = '{0, 32'h1, 1, 1, 0, 32'h0, START};
    vt[17] = '{0, 32'h1, 1, 0, 0, 32'h0, WAIT_DONE};
    vt[18] = '{0, 32'h1, 1, 0, 1, 32'h0, CLEAR};
    vt[19] = '{0, 32'h1, 1, 0, 0, 32'h0, IDLE};
    vt[20] = '{0, 32'h1, 0, 1, 0, 32'h0, START};
    vt[21] = '{0, 32'h0, 0, 0, 0, 32'h0, WAIT_DONE};
    vt[22] = '{1, 32'h0, 1, 0, 0, 32'h0, IDLE};
    vt[23] = '{0, 32'h0, 1, 0, 0, 32'h0, IDLE};
    vt[24] = '{0, 32'h2, 0, 0, 0, 32'h2, IDLE};
    for (int i = 0; i < 25; i++) begin
      rst = vt[i].rst;
      bus.control_i = vt[i].ctrl;
      bus.tx_done_i = vt[i].done;
      step();
      chk($sformatf("v%0d tx_start", i), 32'(bus.tx_start_o), 32'(vt[i].start));
      chk($sformatf("v%0d we", i), 32'(bus.we_reg_control), 32'(vt[i].we));
      chk($sformatf("v%0d control_o", i), bus.control_o, vt[i].ctrl_o);
      chk($sformatf("v%0d state", i), 32'(dut.state), 32'(vt[i].st));
    end
    // Continuous request with done held high: period-4 frames, pulses never overlap.
    bus.control_i = 32'h1;
    bus.tx_done_i = 1'b1;
    starts = 0;
    wes = 0;
    both = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      starts += int'(bus.tx_start_o);
      wes += int'(bus.we_reg_control);
      both += int'(bus.tx_start_o && bus.we_reg_control);
    end
    chk("b2b starts", 32'(starts), 32'd5);
    chk("b2b writes", 32'(wes), 32'd5);
    chk("b2b overlap", 32'(both), 32'd0);
    chk("b2b end state", 32'(dut.state), 32'(IDLE));
    bus.control_i = 32'h0;
    bus.tx_done_i = 1'b0;
    step();
`ifdef FSM_TX_UART_TIMEOUT_EN
    bus.control_i = 32'h1;
    step();
    chk("to start", 32'(bus.tx_start_o), 32'd1);
    waits = 0;
    wes = 0;
    for (int i = 0; i < 20 && wes == 0; i++) begin
      step();
      if (dut.state == WAIT_DONE) waits++;
      if (bus.we_reg_control) begin
        wes = 1;
        chk("to control_o", bus.control_o, 32'h2);
      end
    end
    chk("to write seen", 32'(wes), 32'd1);
    chk("to wait cycles", 32'(waits), 32'd8);
    bus.control_i = 32'h0;
    step();
    chk("to idle", 32'(dut.state), 32'(IDLE));
    chk("to err cleared", bus.control_o, 32'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
